song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/synth_pkg.sv | 22 ++
 rtl/song_sequencer_if.sv | 21 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/song_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_song_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the song sequencer: FSM state encoding,
// step-memory geometry and the empty-keycode value driven when silent.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

    localparam int          NUM_STEPS   = 32;
    localparam logic [7:0]  KEY_EMPTY   = 8'h00;
    localparam logic [4:0]  LAST_STEP   = 5'd31;
    localparam logic [31:0] SONG_SILENT = {4{KEY_EMPTY}};

    // Duration words are stored as 16 bits and read back zero-extended.
    function automatic logic [31:0] dur_readback(input logic [15:0] dur);
        return {16'h0000, dur};
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Word-addressed register bus into the song sequencer's note/duration memory.
interface song_sequencer_if;
    logic [5:0]  seq_address;
    logic        seq_write;
    logic [31:0] seq_writedata;
    logic [31:0] seq_readdata;

    modport master (
        output seq_address,
        output seq_write,
        output seq_writedata,
        input  seq_readdata
    );

    modport slave (
        input  seq_address,
        input  seq_write,
        input  seq_writedata,
        output seq_readdata
    );
endinterface

// File: rtl/tick_prescaler.sv
// Tempo divider: counts 0..TICK_DIV-1 and flags the last count as a tick.
// clear restarts the count so a note's first tick is a full period away.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_r;

    // Free-running divider with synchronous clear and wrap at the last count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_r <= CW'(1'b0);
        end else if (clear) begin
            count_r <= CW'(1'b0);
        end else if (count_r == LAST) begin
            count_r <= CW'(1'b0);
        end else begin
            count_r <= count_r + CW'(1'b1);
        end
    end

    assign tick = (count_r == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Step sequencer that plays up to 32 four-key chords from a small memory.
// Each step holds its chord for dur ticks, then inserts GAP_TICKS of silence
// so the synth sees a release between repeated notes. A zero duration ends
// the song; loop_en decides between replay and stopping with a done pulse.
module song_sequencer
    import synth_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 10
) (
    input  logic                CLK,
    input  logic                RESET,
    song_sequencer_if.slave     bus,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic [31:0]         song,
    output logic                busy,
    output logic                done,
    output logic [4:0]          step
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_TICKS);

    logic [31:0] note_mem_r [NUM_STEPS];
    logic [15:0] dur_mem_r  [NUM_STEPS];

    seq_state_t  state_r, state_s;
    logic [4:0]  step_r, step_s;
    logic [31:0] song_r, song_s;
    logic        done_r, done_s;
    logic [15:0] rem_r, rem_s;

    logic        clear_s;
    logic        tick_s;
    logic [31:0] rd_data_s;
    logic [15:0] fetch_dur_s;
    logic [31:0] fetch_note_s;

    seq_state_t  adv_state_s;
    logic [4:0]  adv_step_s;
    logic        adv_done_s;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .clear (clear_s),
        .tick  (tick_s)
    );

    // Step memory: bus writes land in any state; the playing step keeps its
    // own latched copy, so edits show up only at that step's next fetch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                note_mem_r[i] <= 32'h0000_0000;
                dur_mem_r[i]  <= 16'h0000;
            end
        end else if (bus.seq_write) begin
            if (bus.seq_address[5]) begin
                dur_mem_r[bus.seq_address[4:0]] <= bus.seq_writedata[15:0];
            end else begin
                note_mem_r[bus.seq_address[4:0]] <= bus.seq_writedata;
            end
        end
    end

    // Combinational bus readback of the addressed note or duration word.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        if (bus.seq_address[5]) begin
            rd_data_s = dur_readback(dur_mem_r[bus.seq_address[4:0]]);
        end else begin
            rd_data_s = note_mem_r[bus.seq_address[4:0]];
        end
    end

    assign bus.seq_readdata = rd_data_s;
    assign fetch_dur_s      = dur_mem_r[step_r];
    assign fetch_note_s     = note_mem_r[step_r];

    // Where to go once a step's sound and silence are both finished.
    always_comb begin
        adv_state_s = FETCH;
        adv_step_s  = step_r + 5'd1;
        adv_done_s  = 1'b0;
        if (step_r == LAST_STEP) begin
            if (loop_en) begin
                adv_state_s = FETCH;
                adv_step_s  = 5'd0;
            end else begin
                adv_state_s = IDLE;
                adv_step_s  = step_r;
                adv_done_s  = 1'b1;
            end
        end else begin
            adv_state_s = FETCH;
        end
    end

    // Next-state and next-output logic; stop overrides start, start restarts.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        song_s  = song_r;
        done_s  = 1'b0;
        rem_s   = rem_r;
        clear_s = (state_r == IDLE) || (state_r == FETCH);

        if (stop && (state_r != IDLE)) begin
            state_s = IDLE;
            song_s  = SONG_SILENT;
        end else if (start) begin
            state_s = FETCH;
            step_s  = 5'd0;
            song_s  = SONG_SILENT;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                    song_s  = SONG_SILENT;
                end
                FETCH: begin
                    if (fetch_dur_s == 16'h0000) begin
                        // An empty song never loops, even with loop_en set.
                        if ((step_r != 5'd0) && loop_en) begin
                            state_s = FETCH;
                            step_s  = 5'd0;
                        end else begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                        end
                    end else begin
                        state_s = PLAY;
                        song_s  = fetch_note_s;
                        rem_s   = fetch_dur_s;
                    end
                end
                PLAY: begin
                    if (tick_s) begin
                        if (rem_r == 16'd1) begin
                            song_s = SONG_SILENT;
                            if (GAP_TICKS == 0) begin
                                state_s = adv_state_s;
                                step_s  = adv_step_s;
                                done_s  = adv_done_s;
                            end else begin
                                state_s = GAP;
                                rem_s   = GAP_LOAD;
                            end
                        end else begin
                            rem_s = rem_r - 16'd1;
                        end
                    end else begin
                        rem_s = rem_r;
                    end
                end
                GAP: begin
                    if (tick_s) begin
                        if (rem_r == 16'd1) begin
                            state_s = adv_state_s;
                            step_s  = adv_step_s;
                            done_s  = adv_done_s;
                        end else begin
                            rem_s = rem_r - 16'd1;
                        end
                    end else begin
                        rem_s = rem_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    song_s  = SONG_SILENT;
                end
            endcase
        end
    end

    // State and output registers; reset aborts play without a done pulse.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= IDLE;
            step_r  <= 5'd0;
            song_r  <= SONG_SILENT;
            done_r  <= 1'b0;
            rem_r   <= 16'h0000;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            song_r  <= song_s;
            done_r  <= done_s;
            rem_r   <= rem_s;
        end
    end

    assign song = song_r;
    assign busy = (state_r != IDLE);
    assign done = done_r;
    assign step = step_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a cycle-count reference model of
// the song playback is compared against the DUT after every clock edge,
// with directed scenarios pinned by hand-computed values and a random phase.
module tb_song_sequencer;

    localparam int TD = 4;
    localparam int GT = 1;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_PLAY  = 2;
    localparam int M_GAP   = 3;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [31:0] song;
    logic        busy;
    logic        done;
    logic [4:0]  step;

    song_sequencer_if bus ();

    song_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus.slave),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .song    (song),
        .busy    (busy),
        .done    (done),
        .step    (step)
    );

    always #5 CLK = ~CLK;

    // Reference model: playback expressed as whole-cycle countdowns.
    int          m_mode;
    int          m_left;
    int          m_step;
    logic [31:0] m_song;
    logic        m_done;
    logic [31:0] m_note [32];
    logic [15:0] m_dur  [32];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_left = 0;
        m_step = 0;
        m_song = 32'h0;
        m_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_note[i] = 32'h0;
            m_dur[i]  = 16'h0;
        end
    endtask

    task automatic model_next();
        if (m_step == 31) begin
            if (loop_en) begin
                m_step = 0;
                m_mode = M_FETCH;
            end else begin
                m_mode = M_IDLE;
                m_done = 1'b1;
            end
        end else begin
            m_step = m_step + 1;
            m_mode = M_FETCH;
        end
    endtask

    task automatic model_update();
        int d;
        if (RESET) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (stop && (m_mode != M_IDLE)) begin
            m_mode = M_IDLE;
            m_song = 32'h0;
        end else if (start) begin
            m_mode = M_FETCH;
            m_step = 0;
            m_song = 32'h0;
        end else begin
            case (m_mode)
                M_FETCH: begin
                    d = int'(m_dur[m_step]);
                    if (d == 0) begin
                        if ((m_step != 0) && loop_en) m_step = 0;
                        else begin
                            m_mode = M_IDLE;
                            m_done = 1'b1;
                        end
                    end else begin
                        m_song = m_note[m_step];
                        m_left = d * TD;
                        m_mode = M_PLAY;
                    end
                end
                M_PLAY: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_song = 32'h0;
                        if (GT > 0) begin
                            m_mode = M_GAP;
                            m_left = GT * TD;
                        end else model_next();
                    end
                end
                M_GAP: begin
                    m_left = m_left - 1;
                    if (m_left == 0) model_next();
                end
                default: ;
            endcase
        end
        if (bus.seq_write) begin
            if (bus.seq_address[5]) m_dur[bus.seq_address[4:0]] = bus.seq_writedata[15:0];
            else m_note[bus.seq_address[4:0]] = bus.seq_writedata;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        if (a[5]) return {16'h0000, m_dur[a[4:0]]};
        return m_note[a[4:0]];
    endfunction

    // One clock: model absorbs the sampled inputs, DUT outputs checked 1 ns later.
    task automatic step_clk();
        @(posedge CLK);
        model_update();
        #1;
        check("song", song, m_song);
        check("busy", {31'h0, busy}, {31'h0, (m_mode != M_IDLE)});
        check("done", {31'h0, done}, {31'h0, m_done});
        check("step", {27'h0, step}, 32'(m_step[4:0]));
        check("readdata", bus.seq_readdata, model_read(bus.seq_address));
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        bus.seq_address   = a;
        bus.seq_writedata = d;
        bus.seq_write     = 1'b1;
        step_clk();
        bus.seq_write     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step_clk();
        start = 1'b0;
    endtask

    initial begin
        int n_note, first_note, n_done, done_at, busy_at;
        int r0, r1, n;
        logic prev;
        logic found;

        bus.seq_address   = 6'h00;
        bus.seq_write     = 1'b0;
        bus.seq_writedata = 32'h0;
        model_reset();

        RESET = 1'b1;
        repeat (2) step_clk();
        check("reset_song", song, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_step", {27'h0, step}, 32'h0);
        RESET = 1'b0;
        step_clk();

        // Single step of 3 ticks, then end of song.
        bus_wr(6'h00, 32'h0000_1417);
        bus_wr(6'h20, 32'h0000_0003);
        loop_en = 1'b0;
        pulse_start();
        n_note = 0; first_note = -1; n_done = 0; done_at = -1; busy_at = -1;
        for (int k = 0; k < 25; k++) begin
            if (song == 32'h0000_1417) begin
                n_note++;
                if (first_note < 0) first_note = k;
            end
            if (done) begin
                n_done++;
                done_at = k;
            end
            if (k == 18) busy_at = int'(busy);
            step_clk();
        end
        check("one_first_note", 32'(first_note), 32'd1);
        check("one_note_cycles", 32'(n_note), 32'd12);
        check("one_done_count", 32'(n_done), 32'd1);
        check("one_done_cycle", 32'(done_at), 32'd18);
        check("one_busy_at_done", 32'(busy_at), 32'd0);

        // Looping: each pass is fetch+12 play+4 gap plus the end-of-song fetch.
        loop_en = 1'b1;
        pulse_start();
        r0 = -1; r1 = -1; n_done = 0; prev = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if ((song == 32'h0000_1417) && !prev) begin
                if (r0 < 0) r0 = k;
                else if (r1 < 0) r1 = k;
            end
            prev = (song == 32'h0000_1417);
            if (done) n_done++;
            step_clk();
        end
        check("loop_period", 32'(r1 - r0), 32'd18);
        check("loop_no_done", 32'(n_done), 32'd0);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check("stop_song", song, 32'h0);
        check("stop_busy", {31'h0, busy}, 32'h0);
        check("stop_done", {31'h0, done}, 32'h0);
        step_clk();

        // Empty song ends immediately even with loop_en set.
        bus_wr(6'h20, 32'h0);
        loop_en = 1'b1;
        pulse_start();
        check("empty_fetch_busy", {31'h0, busy}, 32'h1);
        step_clk();
        check("empty_done", {31'h0, done}, 32'h1);
        check("empty_idle", {31'h0, busy}, 32'h0);
        step_clk();

        // All 32 steps one tick long, no loop.
        for (int i = 0; i < 32; i++) bus_wr(6'h20 | 6'(i), 32'h1);
        loop_en = 1'b0;
        pulse_start();
        n = 0;
        while (!done && (n < 400)) begin
            step_clk();
            n++;
        end
        check("all_done_seen", {31'h0, done}, 32'h1);
        check("all_cycles", 32'(n), 32'd288);
        check("all_last_step", {27'h0, step}, 32'd31);
        step_clk();
        check("all_done_once", {31'h0, done}, 32'h0);

        // Editing the playing step only takes effect at its next fetch.
        bus_wr(6'h00, 32'h0000_1417);
        bus_wr(6'h20, 32'hdead_0003);
        bus_wr(6'h21, 32'h0);
        bus.seq_address = 6'h20;
        #1;
        check("dur_readback", bus.seq_readdata, 32'h0000_0003);
        loop_en = 1'b1;
        pulse_start();
        repeat (3) step_clk();
        check("edit_before", song, 32'h0000_1417);
        bus_wr(6'h00, 32'h2a2b_2c2d);
        check("edit_latched", song, 32'h0000_1417);
        bus.seq_address = 6'h00;
        #1;
        check("edit_readback", bus.seq_readdata, 32'h2a2b_2c2d);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!found) begin
                step_clk();
                if (song == 32'h2a2b_2c2d) found = 1'b1;
            end
        end
        check("edit_next_fetch", {31'h0, found}, 32'h1);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;

        // Asynchronous reset in the middle of step 1's PLAY.
        bus_wr(6'h01, 32'h0000_3c3d);
        bus_wr(6'h21, 32'h3);
        loop_en = 1'b0;
        pulse_start();
        repeat (22) step_clk();
        check("pre_reset_step", {27'h0, step}, 32'd1);
        check("pre_reset_song", song, 32'h0000_3c3d);
        #3;
        RESET = 1'b1;
        model_reset();
        #1;
        check("areset_song", song, 32'h0);
        check("areset_busy", {31'h0, busy}, 32'h0);
        check("areset_step", {27'h0, step}, 32'h0);
        bus.seq_address = 6'h00;
        #1;
        check("areset_mem", bus.seq_readdata, 32'h0);
        step_clk();
        RESET = 1'b0;
        step_clk();
        check("areset_no_done", {31'h0, done}, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 9; i++) bus_wr(6'h20 | 6'(i), (i == 8) ? 32'h0 : 32'((i % 3) + 1));
        for (int i = 0; i < 9; i++) bus_wr(6'(i), $urandom());
        for (int c = 0; c < 3000; c++) begin
            bus.seq_address = 6'($urandom_range(0, 63));
            bus.seq_write   = ($urandom_range(0, 9) == 0);
            if (bus.seq_address[5])
                bus.seq_writedata = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 3))};
            else
                bus.seq_writedata = $urandom();
            start = ($urandom_range(0, 49) == 0);
            stop  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            step_clk();
        end
        bus.seq_write = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        step_clk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
